// File: rtl/ring_word_reader_if.sv
// Bus between the ring word reader, the writer-side pointer and the dual-port RAM read port.
// master is the reader itself; slave is the surrounding writer/RAM/consumer.
interface ring_word_reader_if;
  logic [6:0]  wptr;
  logic        flush;
  logic [4:0]  ra;
  logic [15:0] rd;
  logic [5:0]  rptr;
  logic [15:0] dout;
  logic        dvalid;
  logic        dready;
  logic [5:0]  level;
  logic        ovf;

  modport master (
    input  wptr, flush, rd, dready,
    output ra, rptr, dout, dvalid, level, ovf
  );

  modport slave (
    output wptr, flush, rd, dready,
    input  ra, rptr, dout, dvalid, level, ovf
  );
endinterface

// File: rtl/ring_word_reader.sv
// Reads 16-bit words out of a 64-byte ring through a registered-output dual-port RAM.
//   state | meaning
//   IDLE  | waiting for a complete unread word (and no overrun)
//   ADDR  | ra presented to the RAM
//   DATA  | RAM data captured into dout, rptr advanced
//   OUT   | dout held until the consumer accepts it
module ring_word_reader (
  input  logic                       clk,
  input  logic                       rstn,
  ring_word_reader_if.master         bus
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, OUT} state_t;

  state_t      state, state_next;
  logic [4:0]  ra_q, ra_next;
  logic [5:0]  rptr_q, rptr_next;
  logic [15:0] dout_q, dout_next;
  logic        dvalid_q, dvalid_next;
  logic        ovf_q, ovf_next;
  logic [5:0]  level;

  // A trailing odd byte drops out because only wptr[6:1] is used.
  assign level = bus.wptr[6:1] - rptr_q;

  always_comb begin
    state_next  = state;
    ra_next     = ra_q;
    rptr_next   = rptr_q;
    dout_next   = dout_q;
    dvalid_next = dvalid_q;
    ovf_next    = ovf_q | (level > 6'd32);

    case (state)
      IDLE: begin
        // Overrun seen this very edge also blocks the fetch.
        if ((level != 6'd0) && !ovf_next) begin
          ra_next    = rptr_q[4:0];
          state_next = ADDR;
        end
      end
      ADDR: state_next = DATA;
      DATA: begin
        dout_next   = bus.rd;
        dvalid_next = 1'b1;
        rptr_next   = rptr_q + 6'd1;
        state_next  = OUT;
      end
      OUT: begin
        if (dvalid_q && bus.dready) begin
          dvalid_next = 1'b0;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (bus.flush) begin
      rptr_next   = bus.wptr[6:1];
      dvalid_next = 1'b0;
      ovf_next    = 1'b0;
      state_next  = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      ra_q     <= '0;
      rptr_q   <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state    <= state_next;
      ra_q     <= ra_next;
      rptr_q   <= rptr_next;
      dout_q   <= dout_next;
      dvalid_q <= dvalid_next;
      ovf_q    <= ovf_next;
    end
  end

  assign bus.ra     = ra_q;
  assign bus.rptr   = rptr_q;
  assign bus.dout   = dout_q;
  assign bus.dvalid = dvalid_q;
  assign bus.level  = level;
  assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_ring_word_reader.sv
// Directed-sequence bench for ring_word_reader with random data and a byte-queue reference model.
module tb_ring_word_reader;

  logic clk;
  logic rstn;
  ring_word_reader_if bus();

  ring_word_reader u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [64];
  always @(posedge clk) bus.rd <= {mem[{bus.ra, 1'b1}], mem[{bus.ra, 1'b0}]};

  int         checks = 0;
  int         errors = 0;
  logic [6:0] wp = '0;
  int         m_rd = 0;
  logic [7:0] q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] exp_level();
    int d;
    d = (int'(wp) >> 1) - m_rd;
    return 32'(d & 63);
  endfunction

  task automatic put_byte(input logic [7:0] b);
    mem[wp[5:0]] = b;
    q.push_back(b);
    wp = wp + 7'd1;
  endtask

  task automatic put_random(input int n);
    for (int i = 0; i < n; i++) put_byte(8'($urandom));
  endtask

  task automatic publish();
    bus.wptr = wp;
    #1;
  endtask

  task automatic flush_model();
    logic [7:0] last;
    m_rd = int'(wp) >> 1;
    if (wp[0]) begin
      last = q[$];
      q.delete();
      q.push_back(last);
    end else begin
      q.delete();
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (bus.dvalid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus.dvalid), 32'd1);
  endtask

  task automatic deliver(input int stall);
    logic [15:0] w;
    logic [15:0] held;
    wait_valid("dvalid_timeout");
    if (bus.dvalid !== 1'b1) return;
    w = (q.size() >= 2) ? {q[1], q[0]} : 16'hdead;
    chk("dout_word", 32'(bus.dout), 32'(w));
    held = bus.dout;
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("stall_dout", 32'(bus.dout), 32'(held));
      chk("stall_dvalid", 32'(bus.dvalid), 32'd1);
    end
    bus.dready = 1'b1;
    tick();
    bus.dready = 1'b0;
    if (q.size() >= 2) begin
      void'(q.pop_front());
      void'(q.pop_front());
    end
    m_rd = (m_rd + 1) % 64;
    chk("dvalid_clear", 32'(bus.dvalid), 32'd0);
    chk("level_after", 32'(bus.level), exp_level());
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    wp = '0;
    m_rd = 0;
    q.delete();
    publish();
    tick();
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    bus.wptr = '0;
    bus.flush = 1'b0;
    bus.dready = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;

    // Reset values
    do_reset();
    chk("rst_rptr", 32'(bus.rptr), 32'd0);
    chk("rst_ra", 32'(bus.ra), 32'd0);
    chk("rst_dout", 32'(bus.dout), 32'd0);
    chk("rst_dvalid", 32'(bus.dvalid), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    chk("rst_level", 32'(bus.level), 32'd0);

    // Empty ring with dready held high
    bus.dready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("empty_dvalid", 32'(bus.dvalid), 32'd0);
      chk("empty_level", 32'(bus.level), 32'd0);
    end
    bus.dready = 1'b0;

    // Single word: 3-cycle latency
    put_byte(8'h34);
    put_byte(8'h12);
    publish();
    chk("single_level", 32'(bus.level), 32'd1);
    tick();
    chk("lat_c1", 32'(bus.dvalid), 32'd0);
    tick();
    chk("lat_c2", 32'(bus.dvalid), 32'd0);
    tick();
    chk("lat_c3", 32'(bus.dvalid), 32'd1);
    deliver(0);
    chk("single_rptr", 32'(bus.rptr), 32'd1);

    // Odd byte gives no word until completed
    put_random(1);
    publish();
    for (int i = 0; i < 6; i++) tick();
    chk("odd_dvalid", 32'(bus.dvalid), 32'd0);
    chk("odd_level", 32'(bus.level), 32'd0);
    chk("odd_rptr", 32'(bus.rptr), 32'd1);
    put_random(1);
    publish();
    deliver(2);
    for (int i = 0; i < 6; i++) tick();
    chk("odd_once", 32'(bus.dvalid), 32'd0);
    chk("odd_rptr2", 32'(bus.rptr), 32'd2);

    // Full ring, backpressure, drain with wrap
    do_reset();
    put_random(64);
    publish();
    chk("full_level", 32'(bus.level), 32'd32);
    tick();
    chk("full_ovf", 32'(bus.ovf), 32'd0);
    deliver(10);
    for (int i = 1; i < 32; i++) deliver(int'($urandom_range(3, 0)));
    chk("wrap_rptr", 32'(bus.rptr), 32'd32);
    chk("wrap_ra", 32'(bus.ra), 32'd31);
    chk("wrap_level", 32'(bus.level), 32'd0);
    chk("wrap_ovf", 32'(bus.ovf), 32'd0);

    // Overrun then flush
    do_reset();
    put_random(66);
    publish();
    chk("ovr_level", 32'(bus.level), 32'd33);
    tick();
    chk("ovr_ovf", 32'(bus.ovf), 32'd1);
    for (int i = 0; i < 5; i++) tick();
    chk("ovr_nofetch", 32'(bus.dvalid), 32'd0);
    chk("ovr_sticky", 32'(bus.ovf), 32'd1);
    chk("ovr_rptr", 32'(bus.rptr), 32'd0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    flush_model();
    chk("flush_ovf", 32'(bus.ovf), 32'd0);
    chk("flush_rptr", 32'(bus.rptr), 32'd33);
    chk("flush_level", 32'(bus.level), exp_level());

    // Flush during DATA, next fetch from new rptr
    put_random(4);
    publish();
    tick();
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    flush_model();
    chk("fdata_dvalid", 32'(bus.dvalid), 32'd0);
    chk("fdata_rptr", 32'(bus.rptr), 32'd35);
    for (int i = 0; i < 4; i++) tick();
    chk("fdata_idle", 32'(bus.dvalid), 32'd0);
    put_random(2);
    publish();
    deliver(1);
    chk("fdata_ra", 32'(bus.ra), 32'd3);

    // Flush wins over a simultaneous handshake
    put_random(2);
    publish();
    wait_valid("fhs_valid");
    bus.flush = 1'b1;
    bus.dready = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.dready = 1'b0;
    flush_model();
    chk("fhs_dvalid", 32'(bus.dvalid), 32'd0);
    chk("fhs_rptr", 32'(bus.rptr), 32'd37);

    // Reset while in OUT
    put_random(2);
    publish();
    wait_valid("rout_valid");
    rstn = 1'b0;
    tick();
    m_rd = 0;
    chk("rout_dvalid", 32'(bus.dvalid), 32'd0);
    chk("rout_rptr", 32'(bus.rptr), 32'd0);
    chk("rout_ra", 32'(bus.ra), 32'd0);
    chk("rout_dout", 32'(bus.dout), 32'd0);
    chk("rout_ovf", 32'(bus.ovf), 32'd0);
    chk("rout_level", 32'(bus.level), exp_level());
    rstn = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ring_word_reader.md
RING_WORD_READER -- requirements
Module: ring_word_reader

Interface
REQ-001 The block SHALL have no parameters; geometry is fixed at 64 bytes written, 32 16-bit words read.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rstn  input  1  reset, synchronous and active-low.
REQ-004 wptr  input  7  writer byte pointer: bits [5:0] are the next byte address, bit [6] is the wrap bit.
REQ-005 flush  input  1  synchronous discard of all unread data.
REQ-006 ra  output  5  registered word read address driven to the dual-port RAM.
REQ-007 rd  input  16  RAM read data, valid on the second rising edge after ra changes; byte at address 2*ra is in bits [7:0].
REQ-008 rptr  output  6  reader word pointer: bits [4:0] are the next word, bit [5] is the wrap bit; returned to the writer for full detection.
REQ-009 dout  output  16  registered output word.
REQ-010 dvalid  output  1  dout holds an undelivered word.
REQ-011 dready  input  1  consumer accepts dout.
REQ-012 level  output  6  complete words available: (wptr[6:1] - rptr) mod 64.
REQ-013 ovf  output  1  sticky overrun flag.

Function
REQ-014 level SHALL be combinational from wptr and rptr; a lone odd byte (wptr[0]=1) SHALL NOT count as a word.
REQ-015 The FSM SHALL have four states: IDLE, ADDR, DATA, OUT.
REQ-016 IDLE: if level != 0 and ovf = 0, load ra <= rptr[4:0] and go to ADDR; otherwise stay in IDLE.
REQ-017 ADDR: go unconditionally to DATA, which gives the RAM its read cycle.
REQ-018 DATA: capture dout <= rd, set dvalid <= 1, increment rptr by 1 mod 64, and go to OUT.
REQ-019 OUT: dvalid SHALL stay 1 and dout SHALL stay stable until dvalid & dready is sampled; on that edge clear dvalid and go to IDLE.
REQ-020 Latency SHALL be 3 cycles from the edge on which level becomes nonzero (in IDLE) to dvalid = 1; minimum spacing between words SHALL be 4 cycles.
REQ-021 rptr SHALL wrap from 31 to 0 with bit [5] toggling; ra wraps identically.
REQ-022 level = 32 SHALL be a legal full ring; level > 32 SHALL set ovf on the next edge, and ovf SHALL hold until flush or reset.
REQ-023 While ovf = 1 the block SHALL start no new fetch; a word already in OUT SHALL still be delivered normally.
REQ-024 flush (sampled 1) SHALL, on that edge: set rptr <= wptr[6:1], clear dvalid and ovf, and go to IDLE; it SHALL take priority over every other event, including an in-flight fetch and a simultaneous handshake.
REQ-025 dready while dvalid = 0 SHALL have no effect.
REQ-026 A change of wptr while in ADDR or DATA SHALL NOT disturb the fetch in progress.

Reset
REQ-027 When rstn is sampled 0, the block SHALL set state IDLE, rptr = 0, ra = 0, dout = 0, dvalid = 0 and ovf = 0, overriding flush and every other input.
REQ-028 Reset mid-fetch or in OUT SHALL discard the pending word with no delivery.
REQ-029 level SHALL reflect wptr directly after reset (rptr = 0).

Verification
REQ-030 Empty ring -> with wptr = 0, hold dready = 1 for 20 cycles; dvalid SHALL stay 0 and level SHALL be 0.
REQ-031 Single word -> write bytes 0x34 and 0x12, so wptr = 2; dvalid SHALL rise 3 cycles later with dout = 0x1234; after the handshake, rptr = 1 and level = 0.
REQ-032 Odd byte then completion -> wptr = 1 SHALL give no fetch; advancing wptr to 2 SHALL produce exactly one word.
REQ-033 Backpressure and wrap -> fill 32 words (wptr = 64, level = 32), hold dready = 0 for 10 cycles, then drain; dout SHALL stay stable while stalled, the words SHALL arrive in order, and at the end rptr = 32 with bit [5] = 1 and ra = 31.
REQ-034 Overrun -> set wptr to 66 with rptr = 0, so level = 33; ovf SHALL assert the next cycle and no fetch SHALL start; flush SHALL then clear ovf and leave rptr = 33 and level = 0.
REQ-035 Flush and reset mid-operation -> assert flush during DATA; dvalid SHALL stay 0 and the next fetch SHALL use the new rptr. Then drive rstn = 0 while in OUT; dvalid SHALL be 0 on the next cycle and all outputs SHALL take their reset values.
